// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions for the branch target buffer update path.
//   lc3b_word   : 16-bit machine word (PCs, targets)
//   btb_index_t : BTB set index, taken from PC[5:1]
//   btb_tag_t   : BTB tag, taken from PC[15:6]
//   btb_upd_t   : one queued BTB write {tag, index, target}
//   BTB_SETS    : number of sets in the BTB
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [4:0]  btb_index_t;
  typedef logic [9:0]  btb_tag_t;

  typedef struct packed {
    btb_tag_t   tag;
    btb_index_t index;
    lc3b_word   target;
  } btb_upd_t;

  localparam int BTB_SETS = 32;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } btb_upd_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small FIFO of pending BTB writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear; wins over push and pop on the same edge
//   push       : enqueue push_data (ignored when full)
//   push_data  : entry to enqueue
//   pop        : dequeue the head (ignored when empty)
//   head       : current head entry (meaningless when empty)
//   count      : number of stored entries, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
module btb_upd_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  btb_upd_t                 push_data,
  input  logic                     pop,
  output btb_upd_t                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  btb_upd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences every write into the single-ported BTB. Taken-branch resolutions
// from WB are queued, then written when the ID stage is not using the port,
// when the queue is full, or when the head has waited AGE_MAX cycles. After
// reset and on flush_req the whole array is invalidated one set per cycle.
//   flush_req    : pulse, start full invalidate (ignored during a walk)
//   wb_valid/wb_taken/wb_pc/wb_target : branch resolution from WB
//   id_lookup    : ID stage requests the BTB port
//   wb_stall     : queue full, WB must hold
//   lookup_stall : ID lookup denied this cycle
//   btb_we/btb_inv/btb_index/btb_tag/btb_target : BTB port drive
//   busy         : invalidate walk in progress
module btb_update_ctrl
  import lc3b_types::*;
#(
  parameter int DEPTH   = 4,
  parameter int AGE_MAX = 8,
  parameter int SETS    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_req,
  input  logic       wb_valid,
  input  logic       wb_taken,
  input  lc3b_word   wb_pc,
  input  lc3b_word   wb_target,
  input  logic       id_lookup,
  output logic       wb_stall,
  output logic       lookup_stall,
  output logic       btb_we,
  output logic       btb_inv,
  output btb_index_t btb_index,
  output btb_tag_t   btb_tag,
  output lc3b_word   btb_target,
  output logic       busy
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WALK_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int AGE_W  = $clog2(AGE_MAX + 1);

  btb_upd_state_t    state;
  logic [WALK_W-1:0] walk;
  logic [AGE_W-1:0]  age;

  btb_upd_t          push_data;
  btb_upd_t          head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              clr;
  logic              grant;
  logic              in_run;
  logic              unused_pc0;

  assign unused_pc0 = wb_pc[0];

  assign in_run   = (state == ST_RUN);
  assign wb_stall = (fifo_count == CNT_W'(DEPTH));
  assign push     = wb_valid && wb_taken && !wb_stall;
  assign clr      = in_run && flush_req;

  // A full queue or a stale head takes the port even from a live lookup.
  assign grant = in_run && !fifo_empty &&
                 (!id_lookup || fifo_full || (age >= AGE_W'(AGE_MAX)));

  assign push_data.tag    = wb_pc[15:6];
  assign push_data.index  = wb_pc[5:1];
  assign push_data.target = wb_target;

  btb_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push && !clr),
    .push_data (push_data),
    .pop       (grant),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy         = !in_run;
  assign btb_inv      = !in_run;
  assign btb_we       = grant;
  assign btb_index    = in_run ? head.index : btb_index_t'(walk);
  assign btb_tag      = head.tag;
  assign btb_target   = head.target;
  assign lookup_stall = in_run ? (grant && id_lookup) : id_lookup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FLUSH;
      walk  <= '0;
      age   <= '0;
    end else begin
      case (state)
        ST_FLUSH: begin
          if (walk == WALK_W'(SETS - 1)) begin
            state <= ST_RUN;
            walk  <= '0;
          end else begin
            walk <= walk + 1'b1;
          end
        end
        default: begin
          if (flush_req) begin
            state <= ST_FLUSH;
            walk  <= '0;
          end
        end
      endcase

      // Age measures how long the current head has been denied the port.
      if (clr || fifo_empty || grant) begin
        age <= '0;
      end else if (in_run && (age < AGE_W'(AGE_MAX))) begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_req;
  logic       wb_valid;
  logic       wb_taken;
  lc3b_word   wb_pc;
  lc3b_word   wb_target;
  logic       id_lookup;
  logic       wb_stall;
  logic       lookup_stall;
  logic       btb_we;
  logic       btb_inv;
  btb_index_t btb_index;
  btb_tag_t   btb_tag;
  lc3b_word   btb_target;
  logic       busy;

  int checks = 0;
  int errors = 0;

  btb_update_ctrl #(.DEPTH(4), .AGE_MAX(8), .SETS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_req    (flush_req),
    .wb_valid     (wb_valid),
    .wb_taken     (wb_taken),
    .wb_pc        (wb_pc),
    .wb_target    (wb_target),
    .id_lookup    (id_lookup),
    .wb_stall     (wb_stall),
    .lookup_stall (lookup_stall),
    .btb_we       (btb_we),
    .btb_inv      (btb_inv),
    .btb_index    (btb_index),
    .btb_tag      (btb_tag),
    .btb_target   (btb_target),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_taken(input lc3b_word pc, input lc3b_word tgt);
    wb_valid = 1'b1; wb_taken = 1'b1; wb_pc = pc; wb_target = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_req = 0; wb_valid = 0; wb_taken = 0;
    wb_pc = '0; wb_target = '0; id_lookup = 1'b1;
    #12;
    checks++; if ({busy, btb_inv, btb_we, wb_stall, lookup_stall} !== 5'b11001) begin
      errors++; $display("FAIL reset_ctrl: got %b required 11001", {busy, btb_inv, btb_we, wb_stall, lookup_stall}); end
    checks++; if (btb_index !== 5'd0) begin
      errors++; $display("FAIL reset_index: got %0h required 0", btb_index); end
  endtask

  task automatic test_init_walk();
    @(posedge clk); #1;
    rst_n = 1'b1; id_lookup = 1'b0;
    settle();
    for (int i = 0; i < 32; i++) begin
      checks++; if (btb_inv !== 1'b1 || busy !== 1'b1 || btb_we !== 1'b0 || btb_index !== 5'(i)) begin
        errors++; $display("FAIL walk_%0d: got inv=%b busy=%b we=%b idx=%0h required 1 1 0 %0h", i, btb_inv, busy, btb_we, btb_index, i); end
      if (i == 5) push_taken(16'h0F0A, 16'h4444);
      cyc();
      wb_valid = 1'b0;
      settle();
    end
    checks++; if (busy !== 1'b0 || btb_inv !== 1'b0) begin
      errors++; $display("FAIL walk_end: got busy=%b inv=%b required 0 0", busy, btb_inv); end
    checks++; if (btb_we !== 1'b1 || btb_index !== 5'h05 || btb_tag !== 10'h03C || btb_target !== 16'h4444) begin
      errors++; $display("FAIL walk_retained: got we=%b idx=%0h tag=%0h tgt=%0h required 1 5 3c 4444", btb_we, btb_index, btb_tag, btb_target); end
    cyc();
    checks++; if (btb_we !== 1'b0) begin
      errors++; $display("FAIL walk_drained: got we=%b required 0", btb_we); end
  endtask

  task automatic test_basic_write();
    id_lookup = 1'b0;
    push_taken(16'h3046, 16'h3100);
    cyc();
    wb_valid = 1'b0;
    settle();
    checks++; if (btb_we !== 1'b1 || btb_index !== 5'h03 || btb_tag !== 10'h0C1 || btb_target !== 16'h3100 || lookup_stall !== 1'b0) begin
      errors++; $display("FAIL basic_write: got we=%b idx=%0h tag=%0h tgt=%0h ls=%b required 1 3 c1 3100 0", btb_we, btb_index, btb_tag, btb_target, lookup_stall); end
    cyc();
    checks++; if (btb_we !== 1'b0) begin
      errors++; $display("FAIL basic_after: got we=%b required 0", btb_we); end
  endtask

  task automatic test_age();
    id_lookup = 1'b1;
    push_taken(16'h1234, 16'h2000);
    cyc();
    wb_valid = 1'b0;
    settle();
    for (int k = 0; k < 8; k++) begin
      checks++; if (btb_we !== 1'b0 || lookup_stall !== 1'b0) begin
        errors++; $display("FAIL age_wait_%0d: got we=%b ls=%b required 0 0", k, btb_we, lookup_stall); end
      cyc();
    end
    checks++; if (btb_we !== 1'b1 || lookup_stall !== 1'b1 || btb_index !== 5'h1A || btb_tag !== 10'h048 || btb_target !== 16'h2000) begin
      errors++; $display("FAIL age_grant: got we=%b ls=%b idx=%0h tag=%0h tgt=%0h required 1 1 1a 48 2000", btb_we, lookup_stall, btb_index, btb_tag, btb_target); end
    cyc();
    checks++; if (btb_we !== 1'b0 || lookup_stall !== 1'b0) begin
      errors++; $display("FAIL age_after: got we=%b ls=%b required 0 0", btb_we, lookup_stall); end
  endtask

  task automatic test_full();
    id_lookup = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (wb_stall !== 1'b0) begin
        errors++; $display("FAIL full_fill_%0d: got stall=%b required 0", i, wb_stall); end
      push_taken(16'(2 * i), 16'(16'hA000 + i));
      cyc();
    end
    wb_valid = 1'b0;
    settle();
    checks++; if (wb_stall !== 1'b1 || btb_we !== 1'b1 || lookup_stall !== 1'b1 || btb_target !== 16'hA001 || btb_index !== 5'd1) begin
      errors++; $display("FAIL full_forced: got stall=%b we=%b ls=%b tgt=%0h idx=%0h required 1 1 1 a001 1", wb_stall, btb_we, lookup_stall, btb_target, btb_index); end
    cyc();
    checks++; if (wb_stall !== 1'b0 || btb_we !== 1'b0 || lookup_stall !== 1'b0) begin
      errors++; $display("FAIL full_after: got stall=%b we=%b ls=%b required 0 0 0", wb_stall, btb_we, lookup_stall); end
    id_lookup = 1'b0;
    settle();
    for (int i = 2; i <= 4; i++) begin
      checks++; if (btb_we !== 1'b1 || btb_target !== 16'(16'hA000 + i) || btb_index !== 5'(i)) begin
        errors++; $display("FAIL full_drain_%0d: got we=%b tgt=%0h idx=%0h required 1 %0h %0h", i, btb_we, btb_target, btb_index, 16'hA000 + i, i); end
      cyc();
    end
    checks++; if (btb_we !== 1'b0) begin
      errors++; $display("FAIL full_empty: got we=%b required 0", btb_we); end
  endtask

  task automatic test_flush();
    id_lookup = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_taken(16'(16'h0100 + 2 * i), 16'(16'hB000 + i));
      cyc();
    end
    push_taken(16'h0200, 16'hBEEF);
    flush_req = 1'b1;
    settle();
    checks++; if (btb_we !== 1'b0) begin
      errors++; $display("FAIL flush_pre: got we=%b required 0", btb_we); end
    cyc();
    wb_valid = 1'b0; flush_req = 1'b0; id_lookup = 1'b0;
    settle();
    for (int i = 0; i < 32; i++) begin
      checks++; if (btb_inv !== 1'b1 || busy !== 1'b1 || btb_we !== 1'b0 || btb_index !== 5'(i)) begin
        errors++; $display("FAIL flush_walk_%0d: got inv=%b busy=%b we=%b idx=%0h required 1 1 0 %0h", i, btb_inv, busy, btb_we, btb_index, i); end
      flush_req = (i == 10);
      cyc();
      flush_req = 1'b0;
      settle();
    end
    checks++; if (busy !== 1'b0 || btb_we !== 1'b0 || wb_stall !== 1'b0) begin
      errors++; $display("FAIL flush_end: got busy=%b we=%b stall=%b required 0 0 0", busy, btb_we, wb_stall); end
    cyc();
    checks++; if (btb_we !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_discarded: got we=%b busy=%b required 0 0", btb_we, busy); end
  endtask

  task automatic test_back_to_back();
    id_lookup = 1'b0;
    wb_valid = 1'b1; wb_taken = 1'b0; wb_pc = 16'h0444; wb_target = 16'h5555;
    cyc();
    wb_valid = 1'b0;
    settle();
    checks++; if (btb_we !== 1'b0) begin
      errors++; $display("FAIL not_taken: got we=%b required 0", btb_we); end
    id_lookup = 1'b1;
    push_taken(16'h0010, 16'hC001);
    cyc();
    push_taken(16'h0012, 16'hC002);
    cyc();
    id_lookup = 1'b0;
    push_taken(16'h0014, 16'hC003);
    settle();
    checks++; if (btb_we !== 1'b1 || btb_target !== 16'hC001) begin
      errors++; $display("FAIL b2b_pop_push: got we=%b tgt=%0h required 1 c001", btb_we, btb_target); end
    cyc();
    wb_valid = 1'b0;
    settle();
    checks++; if (btb_we !== 1'b1 || btb_target !== 16'hC002 || btb_index !== 5'h09) begin
      errors++; $display("FAIL b2b_second: got we=%b tgt=%0h idx=%0h required 1 c002 9", btb_we, btb_target, btb_index); end
    cyc();
    checks++; if (btb_we !== 1'b1 || btb_target !== 16'hC003 || btb_index !== 5'h0A) begin
      errors++; $display("FAIL b2b_third: got we=%b tgt=%0h idx=%0h required 1 c003 a", btb_we, btb_target, btb_index); end
    cyc();
    checks++; if (btb_we !== 1'b0) begin
      errors++; $display("FAIL b2b_empty: got we=%b required 0", btb_we); end
  endtask

  task automatic test_reset_mid_drain();
    id_lookup = 1'b1;
    push_taken(16'h0700, 16'hD001);
    cyc();
    push_taken(16'h0702, 16'hD002);
    cyc();
    wb_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    settle();
    checks++; if (busy !== 1'b1 || btb_inv !== 1'b1 || btb_index !== 5'd0 || btb_we !== 1'b0 || lookup_stall !== 1'b1) begin
      errors++; $display("FAIL midreset: got busy=%b inv=%b idx=%0h we=%b ls=%b required 1 1 0 0 1", busy, btb_inv, btb_index, btb_we, lookup_stall); end
    @(posedge clk); #1;
    rst_n = 1'b1; id_lookup = 1'b0;
    for (int i = 0; i < 32; i++) cyc();
    checks++; if (busy !== 1'b0 || btb_we !== 1'b0) begin
      errors++; $display("FAIL midreset_empty: got busy=%b we=%b required 0 0", busy, btb_we); end
  endtask

  initial begin
    test_reset();
    test_init_walk();
    test_basic_write();
    test_age();
    test_full();
    test_flush();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Sequences all writes into the single-ported branch target buffer (32 sets × 4 ways, 10-bit tag, PC[5:1] index). It buffers taken-branch resolutions from writeback in a small FIFO and arbitrates the BTB port between ID-stage lookups and those writes. It also runs a full-array invalidate walk after reset and on request. It sits between the WB stage and the BTB, alongside the ID-stage fetch logic.

## Interface
Parameters:
- DEPTH, 4: update FIFO entries (power of two, ≥2)
- AGE_MAX, 8: cycles a FIFO head may wait before its write preempts a lookup
- SETS, 32: BTB sets walked by invalidate

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_req  in  1  single-cycle pulse requesting full BTB invalidate
- wb_valid  in  1  branch resolved in WB this cycle
- wb_taken  in  1  resolved branch was taken
- wb_pc  in  16 (lc3b_word)  PC of the resolved branch
- wb_target  in  16 (lc3b_word)  resolved target
- id_lookup  in  1  ID stage wants the BTB port this cycle
- wb_stall  out  1  FIFO full; WB must hold its branch
- lookup_stall  out  1  ID lookup denied this cycle
- btb_we  out  1  write one entry (victim chosen by BTB LRU)
- btb_inv  out  1  clear all 4 valid bits of btb_index
- btb_index  out  5  set index
- btb_tag  out  10  tag for write
- btb_target  out  16  target for write
- busy  out  1  invalidate walk in progress

## Operation
- FSM states: FLUSH, RUN. rst_n low → FLUSH, walk index 0, FIFO empty, age 0.
- FLUSH: btb_inv=1, btb_index=walk counter, counter increments each cycle; after index SETS-1 → RUN. busy=1, lookup_stall=id_lookup, btb_we=0.
- RUN: flush_req → FLUSH with counter 0. The FIFO is cleared on that edge, and any push on the same edge is discarded. flush_req during FLUSH is ignored (the walk is not restarted).
- Push: wb_valid & wb_taken & !wb_stall stores {wb_pc[15:6], wb_pc[5:1], wb_target}. This is allowed in both states. Not-taken resolutions are ignored.
- wb_stall = (count==DEPTH), from the registered count. A push while full is dropped (upstream protocol violation).
- Write grant in RUN, FIFO non-empty: grant when !id_lookup, or count==DEPTH, or age≥AGE_MAX.
  - On grant: btb_we=1 with head fields and the head pops. lookup_stall=id_lookup.
  - No grant: lookup_stall=0 and age increments, saturating.
- age resets to 0 on every pop and whenever the FIFO is empty.
- Simultaneous push and pop: count unchanged, both take effect.
- Outputs with no write or invalidate: btb_we=0, btb_inv=0; index/tag/target follow the FIFO head (don't-care when btb_we=0).

## Timing
- btb_we, btb_inv, btb_index, btb_tag, btb_target, lookup_stall, wb_stall and busy are combinational from registered state plus id_lookup.
- Push at edge N → earliest btb_we in cycle N+1.
- Invalidate walk lasts exactly SETS cycles; RUN begins the cycle after index SETS-1.
- Reset values while rst_n low: busy=1, btb_inv=1, btb_index=0, btb_we=0, wb_stall=0, lookup_stall=id_lookup.
- Reset asserted mid-walk or mid-drain returns the block to FLUSH index 0 and empties the FIFO.
- Worst-case write wait with continuous lookups: AGE_MAX cycles.

## Structure
- lc3b_types gains:
  - btb_index_t (5b), btb_tag_t (10b)
  - struct btb_upd_t {tag, index, target}
  - BTB_SETS=32
- One sub-module, btb_upd_fifo: parameterized DEPTH × btb_upd_t, with push/pop/count/full/empty and synchronous clear.
- The FSM, age counter and arbitration live in btb_update_ctrl.

## Test plan
- Reset release → btb_inv=1 for 32 consecutive cycles, index 0..31, busy 1→0 on cycle 32. Pushes in that window are retained and written after.
- RUN, id_lookup=0: push pc=0x3046, target=0x3100 → next cycle btb_we=1, index=0x03, tag=0x0C1, target=0x3100.
- id_lookup held high, one entry queued → write held off 8 cycles, then btb_we=1 with lookup_stall=1 for one cycle.
- Four taken pushes with id_lookup=1 → wb_stall=1. The next cycle write is forced (count==DEPTH), count drops to 3, and wb_stall clears.
- flush_req with 3 entries queued plus a same-cycle push → FIFO empty, 32-cycle walk, no btb_we for discarded entries.
- wb_valid=1, wb_taken=0 → no push, no btb_we; simultaneous push and pop at count=2 keeps count=2.
